// File: rtl/dma_csr_bank.sv
// dma_csr_bank: multi-channel DMA control/status register bank.
// Holds per-channel SRC/DST/LEN/CTRL registers plus a shared W1C interrupt
// status, interrupt enable and ID register, and drives the transfer engines.
//
// Bus handshake: wr_en and rd_en are single-cycle strobes with no
// backpressure, so every access is consumed in the cycle it is presented.
// A read presented in cycle T answers with rvalid=1 and rdata in T+1; err
// reports a rejected access in T+1. rdata holds between responses.
module dma_csr_bank #(
  parameter int          NUM_CH   = 4,
  parameter int          LEN_W    = 16,
  parameter logic [31:0] ID_VALUE = 32'h444D_0002
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic                    rd_en,
  input  logic [31:0]             addr,
  input  logic [31:0]             wdata,
  output logic [31:0]             rdata,
  output logic                    rvalid,
  output logic                    err,
  output logic [NUM_CH*32-1:0]    ch_src,
  output logic [NUM_CH*32-1:0]    ch_dst,
  output logic [NUM_CH*LEN_W-1:0] ch_len,
  output logic [NUM_CH*2-1:0]     ch_mode,
  output logic [NUM_CH-1:0]       ch_start,
  input  logic [NUM_CH-1:0]       ch_done,
  output logic                    irq
);

  logic [NUM_CH*32-1:0]    src_q, src_d, dst_q, dst_d;
  logic [NUM_CH*LEN_W-1:0] len_q, len_d;
  logic [NUM_CH*2-1:0]     mode_q, mode_d;
  logic [NUM_CH-1:0]       busy_q, busy_d, start_q, start_d;
  logic [NUM_CH-1:0]       stat_q, stat_d, en_q, en_d;
  logic [31:0]             rdata_q, rdata_d, rd_val;
  logic                    rvalid_q, rvalid_d, err_q, err_d, irq_q, irq_d;

  logic        base_ok, ch_hit, stat_hit, en_hit, id_hit, mapped;
  logic [3:0]  idx;
  logic [1:0]  reg_sel;
  logic [15:0] busy_ext;
  logic        idx_busy, wr_acc, rd_acc;

  // Address decode: channel window below 0x100, global registers above.
  assign base_ok  = (addr[31:9] == 23'd0) && (addr[1:0] == 2'd0);
  assign idx      = addr[7:4];
  assign reg_sel  = addr[3:2];
  assign ch_hit   = base_ok && !addr[8] && (int'(idx) < NUM_CH);
  assign stat_hit = base_ok && addr[8] && (addr[7:2] == 6'h00);
  assign en_hit   = base_ok && addr[8] && (addr[7:2] == 6'h01);
  assign id_hit   = base_ok && addr[8] && (addr[7:2] == 6'h02);
  assign mapped   = ch_hit || stat_hit || en_hit || id_hit;

  // A busy channel locks all of its registers against writes.
  assign busy_ext = 16'(busy_q);
  assign idx_busy = busy_ext[idx];
  assign wr_acc   = wr_en && mapped && !id_hit && !(ch_hit && idx_busy);
  assign rd_acc   = rd_en && !wr_en;

  // Read mux: current register contents, zero for unmapped addresses.
  always_comb begin
    rd_val = 32'd0;
    for (int n = 0; n < NUM_CH; n++) begin
      if (ch_hit && (int'(idx) == n)) begin
        case (reg_sel)
          2'd0:    rd_val = src_q[n*32 +: 32];
          2'd1:    rd_val = dst_q[n*32 +: 32];
          2'd2:    rd_val = 32'(len_q[n*LEN_W +: LEN_W]);
          default: rd_val = {28'd0, mode_q[n*2 +: 2], busy_q[n], 1'b0};
        endcase
      end
    end
    if (stat_hit)    rd_val = 32'(stat_q);
    else if (en_hit) rd_val = 32'(en_q);
    else if (id_hit) rd_val = ID_VALUE;
  end

  // Next-state logic: accepted writes, start/busy tracking, interrupt status.
  always_comb begin
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    mode_d  = mode_q;
    busy_d  = busy_q & ~ch_done;
    start_d = '0;
    stat_d  = stat_q;
    en_d    = en_q;
    for (int n = 0; n < NUM_CH; n++) begin
      if (wr_acc && ch_hit && (int'(idx) == n)) begin
        case (reg_sel)
          2'd0: src_d[n*32 +: 32] = wdata;
          2'd1: dst_d[n*32 +: 32] = wdata;
          2'd2: len_d[n*LEN_W +: LEN_W] = wdata[LEN_W-1:0];
          default: begin
            mode_d[n*2 +: 2] = wdata[3:2];
            if (wdata[0]) begin
              start_d[n] = 1'b1;
              busy_d[n]  = 1'b1;
            end
          end
        endcase
      end
    end
    if (wr_acc && stat_hit) stat_d = stat_q & ~wdata[NUM_CH-1:0];
    if (wr_acc && en_hit)   en_d   = wdata[NUM_CH-1:0];
    // A completion in the same cycle as a clear keeps its bit set.
    stat_d   = stat_d | ch_done;
    irq_d    = |(stat_q & en_q);
    rvalid_d = rd_acc;
    rdata_d  = rd_acc ? rd_val : rdata_q;
    err_d    = (wr_en && (rd_en || !wr_acc)) || (rd_en && !mapped);
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q    <= '0;
      dst_q    <= '0;
      len_q    <= '0;
      mode_q   <= '0;
      busy_q   <= '0;
      start_q  <= '0;
      stat_q   <= '0;
      en_q     <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      src_q    <= src_d;
      dst_q    <= dst_d;
      len_q    <= len_d;
      mode_q   <= mode_d;
      busy_q   <= busy_d;
      start_q  <= start_d;
      stat_q   <= stat_d;
      en_q     <= en_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      irq_q    <= irq_d;
    end
  end

  assign ch_src   = src_q;
  assign ch_dst   = dst_q;
  assign ch_len   = len_q;
  assign ch_mode  = mode_q;
  assign ch_start = start_q;
  assign rdata    = rdata_q;
  assign rvalid   = rvalid_q;
  assign err      = err_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_dma_csr_bank.sv
// tb_dma_csr_bank: directed and randomized checks of dma_csr_bank against a
// register-level behavioural model of the address map.
module tb_dma_csr_bank;

  localparam int NUM_CH = 4;
  localparam int LEN_W  = 16;

  logic                    clk;
  logic                    rst_n;
  logic                    wr_en, rd_en;
  logic [31:0]             addr, wdata;
  logic [31:0]             rdata;
  logic                    rvalid, err, irq;
  logic [NUM_CH*32-1:0]    ch_src, ch_dst;
  logic [NUM_CH*LEN_W-1:0] ch_len;
  logic [NUM_CH*2-1:0]     ch_mode;
  logic [NUM_CH-1:0]       ch_start, ch_done;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [31:0]       m_src  [NUM_CH];
  logic [31:0]       m_dst  [NUM_CH];
  logic [LEN_W-1:0]  m_len  [NUM_CH];
  logic [1:0]        m_mode [NUM_CH];
  bit                m_busy [NUM_CH];
  logic [NUM_CH-1:0] m_stat, m_en;
  logic [31:0]       m_rdata;
  logic [31:0]       exp_q [$];

  dma_csr_bank #(
    .NUM_CH   (NUM_CH),
    .LEN_W    (LEN_W),
    .ID_VALUE (32'h444D_0002)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .rvalid   (rvalid),
    .err      (err),
    .ch_src   (ch_src),
    .ch_dst   (ch_dst),
    .ch_len   (ch_len),
    .ch_mode  (ch_mode),
    .ch_start (ch_start),
    .ch_done  (ch_done),
    .irq      (irq)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit addr_mapped(input logic [31:0] a);
    if ((a % 32'd4) != 32'd0 || a >= 32'h200) return 1'b0;
    if (a < 32'h100) return (a / 32'd16) < NUM_CH;
    return (a == 32'h100) || (a == 32'h104) || (a == 32'h108);
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    int ch;
    ch = int'(a / 32'd16);
    if (!addr_mapped(a)) return 32'd0;
    if (a < 32'h100) begin
      case (a % 32'd16)
        32'd0:   return m_src[ch];
        32'd4:   return m_dst[ch];
        32'd8:   return 32'(m_len[ch]);
        default: return 32'(m_mode[ch]) * 32'd4 + (m_busy[ch] ? 32'd2 : 32'd0);
      endcase
    end
    if (a == 32'h100) return 32'(m_stat);
    if (a == 32'h104) return 32'(m_en);
    return 32'h444D_0002;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_src[i] = '0; m_dst[i] = '0; m_len[i] = '0; m_mode[i] = '0; m_busy[i] = 1'b0;
    end
    m_stat = '0;
    m_en = '0;
    m_rdata = '0;
    exp_q.delete();
  endtask

  // One bus cycle: predict, clock, compare every output.
  task automatic step(input logic wr, input logic rd, input logic [31:0] a,
                      input logic [31:0] wd, input logic [NUM_CH-1:0] done);
    bit is_chr, acc, e_err, e_rvalid, e_irq;
    int ch, off;
    logic [NUM_CH-1:0]       e_start;
    logic [NUM_CH*32-1:0]    e_src, e_dst;
    logic [NUM_CH*LEN_W-1:0] e_len;
    logic [NUM_CH*2-1:0]     e_mode;
    wr_en = wr; rd_en = rd; addr = a; wdata = wd; ch_done = done;
    ch  = int'(a / 32'd16);
    off = int'(a % 32'd16);
    is_chr = addr_mapped(a) && (a < 32'h100);
    acc = wr && addr_mapped(a) && (a != 32'h108) && !(is_chr && m_busy[ch]);
    e_err = (wr && rd) || (wr && !acc) || (rd && !addr_mapped(a));
    e_rvalid = rd && !wr;
    if (e_rvalid) exp_q.push_back(model_read(a));
    e_irq = |(m_stat & m_en);
    e_start = '0;
    for (int i = 0; i < NUM_CH; i++) if (done[i]) m_busy[i] = 1'b0;
    if (acc) begin
      if (is_chr) begin
        if (off == 0)      m_src[ch] = wd;
        else if (off == 4) m_dst[ch] = wd;
        else if (off == 8) m_len[ch] = wd[LEN_W-1:0];
        else begin
          m_mode[ch] = wd[3:2];
          if (wd[0]) begin
            e_start[ch] = 1'b1;
            m_busy[ch] = 1'b1;
          end
        end
      end else if (a == 32'h100) m_stat = m_stat & ~wd[NUM_CH-1:0];
      else if (a == 32'h104)     m_en = wd[NUM_CH-1:0];
    end
    m_stat = m_stat | done;
    for (int i = 0; i < NUM_CH; i++) begin
      e_src[i*32 +: 32] = m_src[i];
      e_dst[i*32 +: 32] = m_dst[i];
      e_len[i*LEN_W +: LEN_W] = m_len[i];
      e_mode[i*2 +: 2] = m_mode[i];
    end
    @(posedge clk);
    #1;
    check("err", err, e_err);
    check("rvalid", rvalid, e_rvalid);
    if (e_rvalid) m_rdata = exp_q.pop_front();
    check(e_rvalid ? "rdata" : "rdata_hold", rdata, m_rdata);
    check("ch_start", ch_start, e_start);
    check("irq", irq, e_irq);
    check("ch_src", ch_src, e_src);
    check("ch_dst", ch_dst, e_dst);
    check("ch_len", ch_len, e_len);
    check("ch_mode", ch_mode, e_mode);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    step(1'b1, 1'b0, a, d, '0);
  endtask

  task automatic rd(input logic [31:0] a);
    step(1'b0, 1'b1, a, 32'd0, '0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'd0, 32'd0, '0);
  endtask

  // Asynchronous reset: outputs must clear before any clock edge.
  task automatic do_reset();
    wr_en = 0; rd_en = 0; addr = 0; wdata = 0; ch_done = '0;
    rst_n = 1'b0;
    #2;
    check("rst_rdata", rdata, 32'd0);
    check("rst_rvalid", rvalid, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_irq", irq, 1'b0);
    check("rst_start", ch_start, '0);
    check("rst_src", ch_src, '0);
    check("rst_dst", ch_dst, '0);
    check("rst_len", ch_len, '0);
    check("rst_mode", ch_mode, '0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int rv_cnt;
    logic [31:0] a;
    logic [NUM_CH-1:0] dn;
    logic w, r;
    int sel;
    rst_n = 1'b1;
    wr_en = 0; rd_en = 0; addr = 0; wdata = 0; ch_done = '0;
    model_reset();
    #6;
    do_reset();
    idle(2);

    // ID read after reset.
    rd(32'h108);
    check("id_value", rdata, 32'h444D_0002);
    check("id_rvalid", rvalid, 1'b1);

    // Program and start channel 1.
    wr(32'h10, 32'h1000);
    wr(32'h14, 32'h2000);
    wr(32'h18, 32'h40);
    wr(32'h1C, 32'h5);
    check("start_ch1", ch_start, 4'b0010);
    check("mode_ch1", ch_mode[3:2], 2'b01);
    rd(32'h1C);
    check("ctrl_ch1", rdata, 32'h6);
    check("start_once", ch_start, 4'b0000);

    // Busy protection.
    wr(32'h18, 32'h80);
    check("busy_len_err", err, 1'b1);
    wr(32'h1C, 32'h1);
    check("busy_ctrl_err", err, 1'b1);
    check("busy_no_start", ch_start, 4'b0000);
    rd(32'h18);
    check("busy_len_kept", rdata, 32'h40);

    // Interrupt set, irq, W1C, W1C coincident with done.
    wr(32'h104, 32'h2);
    step(1'b0, 1'b0, 32'd0, 32'd0, 4'b0010);
    check("irq_lag", irq, 1'b0);
    idle(1);
    check("irq_set", irq, 1'b1);
    rd(32'h100);
    check("stat_ch1", rdata, 32'h2);
    wr(32'h100, 32'h2);
    idle(1);
    check("irq_clr", irq, 1'b0);
    step(1'b0, 1'b0, 32'd0, 32'd0, 4'b0010);
    step(1'b1, 1'b0, 32'h100, 32'h2, 4'b0010);
    rd(32'h100);
    check("w1c_vs_done", rdata[1], 1'b1);

    // Done on an idle channel; start and done together.
    step(1'b0, 1'b0, 32'd0, 32'd0, 4'b0001);
    wr(32'h2C, 32'h1);
    step(1'b1, 1'b0, 32'h2C, 32'h1, 4'b0100);
    check("start_done_err", err, 1'b1);
    rd(32'h2C);
    check("start_done_idle", rdata, 32'h0);

    // Error cases.
    rd(32'h40);
    check("unmapped_rdata", rdata, 32'd0);
    check("unmapped_err", err, 1'b1);
    wr(32'h102, 32'hF);
    check("misalign_err", err, 1'b1);
    wr(32'h108, 32'h0);
    check("id_wr_err", err, 1'b1);
    step(1'b1, 1'b1, 32'h20, 32'hABCD, '0);
    check("wrrd_err", err, 1'b1);
    check("wrrd_norvalid", rvalid, 1'b0);
    rd(32'h20);
    check("wrrd_landed", rdata, 32'hABCD);

    // Back-to-back reads of distinct registers.
    rv_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      rd((i < 4) ? 32'(i * 4 + 16) : 32'(i * 4 + 16'h0F0));
      if (rvalid) rv_cnt++;
    end
    check("b2b_rvalid_cnt", rv_cnt, 8);

    // Reset in the middle of activity.
    wr(32'h104, 32'hF);
    step(1'b0, 1'b0, 32'd0, 32'd0, 4'b1000);
    wr(32'h0C, 32'h1);
    check("pre_rst_irq", irq, 1'b1);
    do_reset();
    rd(32'h0C);
    check("rst_busy_clr", rdata, 32'h0);
    rd(32'h108);
    check("rst_id", rdata, 32'h444D_0002);

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      sel = $urandom_range(0, 19);
      if (sel < 14)      a = 32'($urandom_range(0, 5) * 16 + $urandom_range(0, 3) * 4);
      else if (sel < 18) a = 32'h100 + 32'($urandom_range(0, 3) * 4);
      else if (sel == 18) a = 32'($urandom_range(0, 5) * 16 + $urandom_range(1, 3));
      else               a = 32'h200 + 32'($urandom_range(0, 15) * 4);
      w = ($urandom_range(0, 9) < 4);
      r = ($urandom_range(0, 9) < 4);
      for (int c = 0; c < NUM_CH; c++) dn[c] = ($urandom_range(0, 7) == 0);
      step(w, r, a, $urandom, dn);
    end
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
